// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lsu
//  Brief    : Load/store unit in front of a word-wide, little-endian data RAM.
//             Sub-word stores use read-modify-write; faults skip the memory.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_lsu #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] c_last_word = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_store;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_bad;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Classify the incoming request from the live inputs while idle.
    always_comb begin
        w_bad = 1'b0;
        case (funct3)
            3'b000, 3'b100: w_bad = 1'b0;
            3'b001, 3'b101: w_bad = addr[0];
            3'b010:         w_bad = (addr[1:0] != 2'b00);
            default:        w_bad = 1'b1;
        endcase
        if (is_store && funct3[2]) begin
            w_bad = 1'b1;
        end
        if ({addr[31:2], 2'b00} > c_last_word) begin
            w_bad = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (w_bad) begin
                        w_next = S_RESP;
                    end else if (is_store && (funct3 == 3'b010)) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:    w_next = r_store ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Lane extraction for loads, straight off the RAM read port.
    always_comb begin
        w_byte = mem_rd[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = mem_rd[7:0];
            2'd1: w_byte = mem_rd[15:8];
            2'd2: w_byte = mem_rd[23:16];
            2'd3: w_byte = mem_rd[31:24];
            default: w_byte = mem_rd[7:0];
        endcase
        w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rd;
        endcase
    end

    // Merge the store data into the previously captured word.
    always_comb begin
        w_merged = r_word;
        case (r_f3)
            3'b000: begin
                case (r_addr[1:0])
                    2'd0: w_merged[7:0]   = r_wdata[7:0];
                    2'd1: w_merged[15:8]  = r_wdata[7:0];
                    2'd2: w_merged[23:16] = r_wdata[7:0];
                    2'd3: w_merged[31:24] = r_wdata[7:0];
                    default: w_merged = r_word;
                endcase
            end
            3'b001: begin
                if (r_addr[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0] = r_wdata[15:0];
                end
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_store <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_word  <= 32'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && req) begin
                r_store <= is_store;
                r_f3    <= funct3;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_fault <= w_bad;
            end
            if (r_state == S_RD) begin
                r_word <= mem_rd;
                if (!r_store) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign done   = (r_state == S_RESP);
    assign err    = (r_state == S_RESP) & r_fault;
    assign rdata  = r_rdata;
    assign mem_re = (r_state == S_RD);
    // Combinational reset gating so a reset landing in WR blocks the write.
    assign mem_we = (r_state == S_WR) & ~rst;
    assign mem_a  = {r_addr[31:2], 2'b00};
    assign mem_wd = (r_state == S_WR) ? w_merged : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_lsu
//  Brief    : Directed, table-driven bench for data_mem_lsu with a RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_lsu;

    logic        clk;
    logic        rst;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] ram [0:1023];
    int          total;
    int          bad;
    int          we_edges;

    data_mem_lsu #(.MEM_BYTES(4096)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = ram[mem_a[11:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_a[11:2]] <= mem_wd;
            we_edges <= we_edges + 1;
        end
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [0:18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int cyc;
        int n_re;
        int n_we;
        int exp_re;
        int exp_we;
        bit timed_out;
        string tag;
        tag = $sformatf("v%0d", idx);
        exp_re = (!v.exp_err && !(v.st && v.f3 == 3'b010)) ? 1 : 0;
        exp_we = (!v.exp_err && v.st) ? 1 : 0;
        n_re = 0;
        n_we = 0;
        timed_out = 1'b0;
        @(negedge clk);
        chk({tag, " ready"}, {31'd0, ready}, 32'd1);
        req = 1'b1;
        is_store = v.st;
        funct3 = v.f3;
        addr = v.a;
        wdata = v.wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        is_store = 1'b0;
        funct3 = 3'd0;
        addr = 32'hFFFF_FFFF;
        wdata = 32'd0;
        cyc = 1;
        forever begin
            if (mem_re) begin
                n_re++;
                chk({tag, " re_addr"}, mem_a, {v.a[31:2], 2'b00});
            end
            if (mem_we) begin
                n_we++;
                chk({tag, " we_addr"}, mem_a, {v.a[31:2], 2'b00});
                chk({tag, " we_data"}, mem_wd, v.exp_wd);
            end
            if (cyc > 1) begin
                chk({tag, " ready_busy"}, {31'd0, ready}, 32'd0);
            end
            if (done) break;
            if (cyc >= 10) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (timed_out) begin
            chk({tag, " timeout_done"}, 32'd0, 32'd1);
        end else begin
            chk({tag, " latency"}, cyc, v.exp_lat);
            chk({tag, " err"}, {31'd0, err}, {31'd0, v.exp_err});
            chk({tag, " rdata"}, rdata, v.exp_rd);
        end
        chk({tag, " n_re"}, n_re, exp_re);
        chk({tag, " n_we"}, n_we, exp_we);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, " ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int dcount;
        int last_done;
        int we_before;
        total = 0;
        bad = 0;
        we_edges = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        ram[0] = 32'h1;
        ram[1] = 32'h1;
        ram[2] = 32'h4;
        ram[3] = 32'h16;

        //          st    f3      addr      wdata          exp_rdata      err  lat exp_wd
        vecs[0]  = '{1'b0, 3'b010, 32'd12,   32'd0,         32'h00000016, 1'b0, 2, 32'd0};
        vecs[1]  = '{1'b1, 3'b010, 32'd16,   32'hDEADBEEF,  32'h00000016, 1'b0, 2, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 3'b010, 32'd16,   32'd0,         32'hDEADBEEF, 1'b0, 2, 32'd0};
        vecs[3]  = '{1'b0, 3'b000, 32'd19,   32'd0,         32'hFFFFFFDE, 1'b0, 2, 32'd0};
        vecs[4]  = '{1'b0, 3'b100, 32'd19,   32'd0,         32'h000000DE, 1'b0, 2, 32'd0};
        vecs[5]  = '{1'b0, 3'b001, 32'd18,   32'd0,         32'hFFFFDEAD, 1'b0, 2, 32'd0};
        vecs[6]  = '{1'b0, 3'b101, 32'd16,   32'd0,         32'h0000BEEF, 1'b0, 2, 32'd0};
        vecs[7]  = '{1'b1, 3'b000, 32'd17,   32'h1234565A,  32'h0000BEEF, 1'b0, 3, 32'hDEAD5AEF};
        vecs[8]  = '{1'b1, 3'b001, 32'd18,   32'h00007777,  32'h0000BEEF, 1'b0, 3, 32'h77775AEF};
        vecs[9]  = '{1'b0, 3'b010, 32'd16,   32'd0,         32'h77775AEF, 1'b0, 2, 32'd0};
        vecs[10] = '{1'b0, 3'b000, 32'd17,   32'd0,         32'h0000005A, 1'b0, 2, 32'd0};
        vecs[11] = '{1'b0, 3'b000, 32'd16,   32'd0,         32'hFFFFFFEF, 1'b0, 2, 32'd0};
        vecs[12] = '{1'b0, 3'b010, 32'd6,    32'd0,         32'hFFFFFFEF, 1'b1, 1, 32'd0};
        vecs[13] = '{1'b1, 3'b001, 32'd5,    32'h00001111,  32'hFFFFFFEF, 1'b1, 1, 32'd0};
        vecs[14] = '{1'b0, 3'b011, 32'd0,    32'd0,         32'hFFFFFFEF, 1'b1, 1, 32'd0};
        vecs[15] = '{1'b1, 3'b100, 32'd0,    32'h000000AA,  32'hFFFFFFEF, 1'b1, 1, 32'd0};
        vecs[16] = '{1'b0, 3'b010, 32'd4096, 32'd0,         32'hFFFFFFEF, 1'b1, 1, 32'd0};
        vecs[17] = '{1'b0, 3'b110, 32'd0,    32'd0,         32'hFFFFFFEF, 1'b1, 1, 32'd0};
        vecs[18] = '{1'b0, 3'b010, 32'd4092, 32'd0,         32'h00000000, 1'b0, 2, 32'd0};

        rst = 1'b1;
        req = 1'b0;
        is_store = 1'b0;
        funct3 = 3'd0;
        addr = 32'd0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst mem_a", mem_a, 32'd0);
        chk("rst mem_wd", mem_wd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst ready", {31'd0, ready}, 32'd1);

        for (int i = 0; i < 19; i++) begin
            run_op(i, vecs[i]);
        end
        chk("ram word16", ram[4], 32'h77775AEF);
        chk("ram word0 untouched", ram[0], 32'h00000001);

        // Reset landing in the WR cycle of a sub-word store.
        we_before = we_edges;
        @(negedge clk);
        req = 1'b1;
        is_store = 1'b1;
        funct3 = 3'b000;
        addr = 32'd0;
        wdata = 32'h000000FF;
        @(posedge clk);
        #1;
        req = 1'b0;
        is_store = 1'b0;
        chk("rmo cyc1 mem_re", {31'd0, mem_re}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rmo mem_we gated", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rmo done", {31'd0, done}, 32'd0);
        chk("rmo ready", {31'd0, ready}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rmo no done", {31'd0, done}, 32'd0);
        end
        chk("rmo we edges", we_edges - we_before, 32'd0);
        chk("rmo ram0", ram[0], 32'h00000001);
        run_op(100, '{1'b0, 3'b010, 32'd0, 32'd0, 32'h00000001, 1'b0, 2, 32'd0});

        // Continuous req: one load accepted every third cycle.
        dcount = 0;
        last_done = -1;
        @(negedge clk);
        req = 1'b1;
        is_store = 1'b0;
        funct3 = 3'b010;
        addr = 32'd8;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                chk("stream rdata", rdata, 32'h00000004);
                if (last_done >= 0) chk("stream spacing", k - last_done, 32'd3);
                last_done = k;
            end
        end
        req = 1'b0;
        chk("stream done count", dcount, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        chk("stream idle", {31'd0, ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
